// File: rtl/ec_control_unit.sv
// Instruction sequencer for the 8-bit accumulator machine: PC/IR, fetch/decode/execute FSM.
// Optional build macro CTRL_SINGLE_STEP_EN adds a 'step' input and a WAIT_STEP idle state.
module ec_control_unit #(
    parameter int                ADDR_W   = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W+2:0]   mem_rdata,
    input  logic                Enter,
    input  logic                Aeq0,
    input  logic                Apos,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [1:0]          Asel,
    output logic                Aload,
    output logic                Sub,
    output logic                Halt,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W+2:0]   ir
);

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_INPUT = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ADD,
        S_SUB,
        S_INPUT,
        S_JZ,
        S_JPOS,
        S_HALTED
`ifdef CTRL_SINGLE_STEP_EN
        , S_WAIT_STEP
`endif
    } state_t;

    // Where reset lands and where every completed instruction returns to.
`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t IDLE_STATE = S_WAIT_STEP;
`else
    localparam state_t IDLE_STATE = S_FETCH;
`endif

    state_t             state;
    opcode_t            opcode;
    logic [ADDR_W-1:0]  ir_addr;

    assign opcode  = opcode_t'(ir[ADDR_W+2 -: 3]);
    assign ir_addr = ir[ADDR_W-1:0];

    // NOTE: all state here uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE_STATE;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            case (state)
`ifdef CTRL_SINGLE_STEP_EN
                S_WAIT_STEP: if (step) state <= S_FETCH;
`endif
                S_FETCH: begin
                    ir    <= mem_rdata;
                    pc    <= pc + ADDR_W'(1);
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD:  state <= S_LOAD;
                        OP_STORE: state <= S_STORE;
                        OP_ADD:   state <= S_ADD;
                        OP_SUB:   state <= S_SUB;
                        OP_INPUT: state <= S_INPUT;
                        OP_JZ:    state <= S_JZ;
                        OP_JPOS:  state <= S_JPOS;
                        default:  state <= S_HALTED;
                    endcase
                end
                S_INPUT: if (Enter) state <= IDLE_STATE;
                S_JZ: begin
                    if (Aeq0) pc <= ir_addr;
                    state <= IDLE_STATE;
                end
                S_JPOS: begin
                    if (Apos) pc <= ir_addr;
                    state <= IDLE_STATE;
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= IDLE_STATE;
            endcase
        end
    end

    // Strobes are decoded from registered state/IR; reset masks them so an
    // aborted instruction never loads or writes on the reset edge.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem_addr = ir_addr;
        mem_we   = 1'b0;
        Aload    = 1'b0;
        Sub      = 1'b0;
        Asel     = 2'b00;
        Halt     = 1'b0;
        case (state)
`ifdef CTRL_SINGLE_STEP_EN
            S_WAIT_STEP: mem_addr = pc;
`endif
            S_FETCH: mem_addr = pc;
            S_LOAD: begin
                Asel  = 2'b10;
                Aload = !reset;
            end
            S_STORE: mem_we = !reset;
            S_ADD:   Aload  = !reset;
            S_SUB: begin
                Sub   = 1'b1;
                Aload = !reset;
            end
            S_INPUT: begin
                Asel  = Enter ? 2'b01 : 2'b00;
                Aload = Enter && !reset;
            end
            S_HALTED: Halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ec_control_unit.sv
// Directed bench for ec_control_unit with a behavioural memory and accumulator around it.
module tb_ec_control_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW+2:0] mem_rdata;
    logic          Enter = 1'b0;
    logic          Aeq0 = 1'b0;
    logic          Apos = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [1:0]    Asel;
    logic          Aload;
    logic          Sub;
    logic          Halt;
    logic [AW-1:0] pc;
    logic [AW+2:0] ir;
`ifdef CTRL_SINGLE_STEP_EN
    logic          step = 1'b1;
`endif

    always #5 clk = ~clk;

    ec_control_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .Enter(Enter),
        .Aeq0(Aeq0), .Apos(Apos),
`ifdef CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .mem_addr(mem_addr), .mem_we(mem_we), .Asel(Asel), .Aload(Aload),
        .Sub(Sub), .Halt(Halt), .pc(pc), .ir(ir)
    );

    // Behavioural memory and accumulator datapath.
    logic [7:0] mem [32];
    logic [7:0] img [32];
    logic       prog_load = 1'b0;
    logic [7:0] acc;
    logic [7:0] in_val = 8'h00;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (prog_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= img[i];
            acc <= 8'h00;
        end else begin
            if (mem_we) mem[mem_addr] <= acc;
            if (Aload) begin
                case (Asel)
                    2'b00:   acc <= Sub ? acc - mem_rdata : acc + mem_rdata;
                    2'b01:   acc <= in_val;
                    2'b10:   acc <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
    endtask

    // Loads the image and resets; returns in cycle 1 (first FETCH).
    task automatic start();
        prog_load = 1'b1;
        reset     = 1'b1;
        tick();
        prog_load = 1'b0;
        reset     = 1'b0;
        #1;
    endtask

    task automatic jump_case(input string tag, input logic [7:0] instr,
                             input logic z, input logic p, input logic [AW-1:0] exp_pc);
        clear_img();
        img[0] = instr;
        Aeq0   = z;
        Apos   = p;
        start();
        repeat (3) tick();
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_addr"}, mem_addr, exp_pc);
    endtask

    int aload_cnt;

    initial begin
        // Reset asserted during ADD execute aborts the load.
        clear_img();
        img[0]  = 8'h4B;
        img[11] = 8'h04;
        start();
        tick();
        tick();
        check("t1_add_aload", Aload, 1);
        reset = 1'b1;
        #1;
        check("t1_rst_aload", Aload, 0);
        check("t1_rst_we", mem_we, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t1_pc", pc, 0);
        check("t1_ir", ir, 0);
        check("t1_aload", Aload, 0);
        check("t1_we", mem_we, 0);
        check("t1_halt", Halt, 0);
        check("t1_addr", mem_addr, 0);
        check("t1_acc", acc, 0);

        // LOAD 10 / ADD 11 / STORE 12.
        clear_img();
        img[0]  = 8'h0A;
        img[1]  = 8'h4B;
        img[2]  = 8'h2C;
        img[10] = 8'd3;
        img[11] = 8'd4;
        start();
        check("t2_fetch_addr", mem_addr, 0);
        for (int c = 1; c <= 9; c++) begin
            check("t2_aload", Aload, (c == 3 || c == 6) ? 1 : 0);
            check("t2_we", mem_we, (c == 9) ? 1 : 0);
            if (c == 3) check("t2_load_asel", Asel, 2'b10);
            if (c == 6) begin
                check("t2_add_asel", Asel, 2'b00);
                check("t2_add_sub", Sub, 0);
            end
            if (c < 9) tick();
        end
        check("t2_store_addr", mem_addr, 12);
        tick();
        check("t2_mem12", mem[12], 7);
        check("t2_acc", acc, 7);
        check("t2_next_pc", pc, 3);

        // INPUT with Enter low 5 EXEC cycles, then high.
        clear_img();
        img[0] = 8'h80;
        in_val = 8'h5A;
        Enter  = 1'b0;
        start();
        aload_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin
                Enter = 1'b1;
                #1;
                check("t3_asel", Asel, 2'b01);
            end
            check("t3_aload", Aload, (c == 8) ? 1 : 0);
            if (Aload) aload_cnt++;
            tick();
        end
        Enter = 1'b0;
        #1;
        check("t3_aload_count", aload_cnt, 1);
        check("t3_next_fetch", mem_addr, 1);
        check("t3_acc", acc, 8'h5A);

        // Conditional jumps, each flag checked against the other held opposite.
        jump_case("t4_jz_taken", 8'hB4, 1'b1, 1'b0, 20);
        jump_case("t4_jz_not",   8'hB4, 1'b0, 1'b1, 1);
        jump_case("t4_jp_taken", 8'hD4, 1'b0, 1'b1, 20);
        jump_case("t4_jp_not",   8'hD4, 1'b1, 1'b0, 1);

        // Jump to 31, LOAD there, PC wraps to 0.
        clear_img();
        img[0]  = 8'hDF;
        img[31] = 8'h0A;
        img[10] = 8'h33;
        Aeq0    = 1'b0;
        Apos    = 1'b1;
        start();
        repeat (3) tick();
        check("t5_pc31", pc, 31);
        check("t5_addr31", mem_addr, 31);
        repeat (3) tick();
        check("t5_wrap_addr", mem_addr, 0);
        check("t5_wrap_pc", pc, 0);
        check("t5_acc", acc, 8'h33);

        // HALT holds until reset.
        clear_img();
        img[0] = 8'hE0;
        start();
        tick();
        tick();
        check("t6_halt_now", Halt, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t6_halt_hold", Halt, 1);
            check("t6_pc_frozen", pc, 1);
        end
        check("t6_ir", ir, 8'hE0);
        check("t6_no_strobe", {mem_we, Aload}, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t6_rst_halt", Halt, 0);
        check("t6_rst_pc", pc, 0);
        check("t6_rst_addr", mem_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
